// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts up to MAX_BURST words; fifo_full stalls but never releases a grant.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int REQ_BITS   = 2,
  parameter int MAX_BURST  = 4,
  parameter int BURST_BITS = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [REQ_BITS-1:0]           grant_id,
  input  logic                          fifo_full,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_write_enable
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_next;
  logic [NUM_REQ-1:0]    grant_next;
  logic [REQ_BITS-1:0]   grant_id_next;
  logic [REQ_BITS-1:0]   last_grant, last_grant_next;
  logic [BURST_BITS-1:0] burst_count, burst_next;
  logic [REQ_BITS-1:0]   winner;
  logic                  winner_found;
  logic                  transfer;
  logic                  release_grant;

  assign transfer          = (|(grant & req_valid)) & ~fifo_full;
  assign req_ready         = grant & {NUM_REQ{~fifo_full}};
  assign fifo_write_enable = transfer;
  assign fifo_data         = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

  assign release_grant = ~req_valid[grant_id] |
                         (transfer & (burst_count == BURST_BITS'(MAX_BURST - 1)));

  // Scan starts just past the last winner, so it carries the lowest priority.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!winner_found &&
          req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        winner       = REQ_BITS'((int'(last_grant) + k) % NUM_REQ);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    grant_id_next   = grant_id;
    last_grant_next = last_grant;
    burst_next      = burst_count;
    case (state)
      IDLE: begin
        grant_next = '0;
        if (winner_found) begin
          state_next      = GRANT;
          grant_next      = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          grant_id_next   = winner;
          last_grant_next = winner;
          burst_next      = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_next = IDLE;
          grant_next = '0;
        end else if (transfer) begin
          burst_next = burst_count + BURST_BITS'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      last_grant  <= REQ_BITS'(NUM_REQ - 1);
      burst_count <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      grant_id    <= grant_id_next;
      last_grant  <= last_grant_next;
      burst_count <= burst_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed stimulus pushes expected FIFO writes
// (cycle, requester, data) into a queue; a negedge monitor pops and compares.
module tb_fifo_write_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic [1:0]      grant_id;
  logic            fifo_full = 1'b0;
  logic [DW-1:0]   fifo_data;
  logic            fifo_write_enable;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] word_of [NR];

  fifo_write_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .REQ_BITS(2), .MAX_BURST(4), .BURST_BITS(2)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .grant_id(grant_id),
    .fifo_full(fifo_full), .fifo_data(fifo_data),
    .fifo_write_enable(fifo_write_enable)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic expect_write(input int at_cyc, input int id);
    wr_t w;
    w.cyc  = at_cyc;
    w.id   = id;
    w.data = word_of[id];
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    step(2);
    #2 reset = 1'b1;
    step(1);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset && fifo_write_enable) begin
      if (exp_q.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL unexpected_write at cycle %0d: id %0d data %h, none expected",
                 cyc, grant_id, fifo_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("write_cycle", 32'(cyc), 32'(w.cyc));
        chk("write_id", 32'(grant_id), 32'(w.id));
        chk("write_data", fifo_data, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < NR; i++) begin
      word_of[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
      req_data[i*DW +: DW] = word_of[i];
    end

    // Reset values
    step(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(fifo_write_enable), 32'h0);
    #2 reset = 1'b1;
    step(1);

    // Single requester 0: 4-word burst, bubble, regrant
    c = cyc;
    req_valid = 4'b0001;
    for (int j = 1; j <= 4; j++) expect_write(c + j, 0);
    wait_to(c + 1);
    chk("t1_grant", 32'(grant), 32'h1);
    wait_to(c + 5);
    chk("t1_bubble", 32'(grant), 32'h0);
    chk("t1_bubble_we", 32'(fifo_write_enable), 32'h0);
    wait_to(c + 6);
    chk("t1_regrant", 32'(grant), 32'h1);
    req_valid = 4'b0000;
    step(3);
    chk("t1_idle", 32'(grant), 32'h0);

    // All four requesting: rotation 0,1,2,3,0
    do_reset();
    c = cyc;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++)
      for (int j = 1; j <= 4; j++) expect_write(c + 5*k + j, k);
    for (int k = 0; k < 4; k++) begin
      wait_to(c + 5*k + 1);
      chk("t2_grant", 32'(grant), 32'(1 << k));
      wait_to(c + 5*k + 5);
      chk("t2_bubble", 32'(grant), 32'h0);
    end
    wait_to(c + 21);
    chk("t2_wrap_grant", 32'(grant), 32'h1);
    req_valid = 4'b0000;
    step(3);

    // Requester 2 alone, FIFO full for 3 cycles after word 2
    do_reset();
    c = cyc;
    req_valid = 4'b0100;
    expect_write(c + 1, 2);
    expect_write(c + 2, 2);
    expect_write(c + 6, 2);
    expect_write(c + 7, 2);
    wait_to(c + 1);
    chk("t3_grant", 32'(grant), 32'h4);
    chk("t3_ready", 32'(req_ready), 32'h4);
    wait_to(c + 3);
    fifo_full = 1'b1;
    #1 chk("t3_full_ready", 32'(req_ready), 32'h0);
    wait_to(c + 5);
    chk("t3_full_hold", 32'(grant), 32'h4);
    chk("t3_full_we", 32'(fifo_write_enable), 32'h0);
    wait_to(c + 6);
    fifo_full = 1'b0;
    wait_to(c + 8);
    chk("t3_release", 32'(grant), 32'h0);
    req_valid = 4'b0000;
    step(2);

    // Requester 1 drops valid after one word while requester 3 waits
    do_reset();
    c = cyc;
    req_valid = 4'b1010;
    expect_write(c + 1, 1);
    for (int j = 4; j <= 7; j++) expect_write(c + j, 3);
    wait_to(c + 1);
    chk("t4_grant1", 32'(grant), 32'h2);
    wait_to(c + 2);
    req_valid = 4'b1000;
    #1 chk("t4_drop_we", 32'(fifo_write_enable), 32'h0);
    wait_to(c + 3);
    chk("t4_idle", 32'(grant), 32'h0);
    wait_to(c + 4);
    chk("t4_grant3", 32'(grant), 32'h8);
    chk("t4_grant_id", 32'(grant_id), 32'h3);
    wait_to(c + 8);
    chk("t4_release", 32'(grant), 32'h0);
    req_valid = 4'b0000;
    step(2);

    // Asynchronous reset mid-burst, then priority restarts at requester 0
    do_reset();
    c = cyc;
    req_valid = 4'b0001;
    expect_write(c + 1, 0);
    expect_write(c + 2, 0);
    wait_to(c + 3);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant), 32'h0);
    chk("t5_async_ready", 32'(req_ready), 32'h0);
    chk("t5_async_we", 32'(fifo_write_enable), 32'h0);
    wait_to(c + 5);
    req_valid = 4'b0110;
    #3 reset = 1'b1;
    expect_write(c + 6, 1);
    wait_to(c + 6);
    chk("t5_first_grant", 32'(grant), 32'h2);
    wait_to(c + 7);
    req_valid = 4'b0000;
    step(3);

    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL pending_writes: got %0d outstanding expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
